// File: rtl/blink_pkg.sv
// Shared constants and helpers for the blink heartbeat block.
package blink_pkg;

    // Half period used when the instantiating level does not choose one:
    // toggle on every rising edge.
    localparam int DEFAULT_HALF_PERIOD = 1;

    // Width needed to hold values below n, never narrower than one bit
    // so a degenerate counter still has a legal declaration.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/blink_prescaler.sv
// Modulo-HALF_PERIOD counter. tick is high while the counter sits at its
// terminal value, so the owner of tick acts on exactly one edge out of
// every HALF_PERIOD.
module blink_prescaler
    import blink_pkg::*;
#(
    parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = clog2_min1(HALF_PERIOD + 1);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] cnt;

    // Terminal-count decode; for HALF_PERIOD=1 this is permanently high.
    assign tick = (cnt == TERMINAL);

    // Counter wraps to zero at terminal count, so it never exceeds HALF_PERIOD-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/blink.sv
// Free-running heartbeat: led toggles once every HALF_PERIOD rising edges,
// giving a 50% duty square wave. led comes straight from a flop.
module blink
    import blink_pkg::*;
#(
    parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD
) (
    input  logic clk,
    input  logic rst,
    output logic led
);

    logic tick;

    blink_prescaler #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Toggle flop, advanced only on the prescaler's terminal-count edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= 1'b0;
        end else if (tick) begin
            led <= ~led;
        end
    end

endmodule

// File: tb/tb_blink.sv
// Bench for blink: three instances (half periods 1, 3, 5) share clock and
// reset; expected led levels come from the edge count since reset release.
module tb_blink;

    logic clk;
    logic rst;
    logic led1;
    logic led3;
    logic led5;

    int checks   = 0;
    int failures = 0;
    int k        = 0;   // rising edges counted since reset release

    blink u_hp1 (
        .clk(clk),
        .rst(rst),
        .led(led1)
    );

    blink #(.HALF_PERIOD(3)) u_hp3 (
        .clk(clk),
        .rst(rst),
        .led(led3)
    );

    blink #(.HALF_PERIOD(5)) u_hp5 (
        .clk(clk),
        .rst(rst),
        .led(led5)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference: after k counted edges the output has toggled floor(k/hp)
    // times starting from 0, so its level is the parity of that count.
    function automatic logic exp_led(input int edges, input int hp);
        return ((edges / hp) % 2) == 1;
    endfunction

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        $display("check %s k=%0d got=%b exp=%b", tag, k, got, exp);
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s k=%0d got=%b exp=%b", tag, k, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_hp1"}, led1, exp_led(k, 1));
        check({tag, "_hp3"}, led3, exp_led(k, 3));
        check({tag, "_hp5"}, led5, exp_led(k, 5));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_hp1"}, led1, 1'b0);
        check({tag, "_hp3"}, led3, 1'b0);
        check({tag, "_hp5"}, led5, 1'b0);
    endtask

    // Advance n rising edges, checking all outputs at each following falling edge.
    task automatic run_edges(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            k++;
            check_all(tag);
        end
    endtask

    // Release on the falling edge: the next rising edge is the first counted one.
    task automatic release_mid();
        rst = 1'b0;
        k = 0;
    endtask

    // Release exactly on a rising edge; the flops sample the old (asserted)
    // value there, so that edge must not count.
    task automatic release_on_edge(input string tag);
        @(posedge clk);
        rst <= 1'b0;
        k = 0;
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int trans;
        int hold;
        int found;
        logic prev;

        // Reset applied and held for three edges.
        rst = 1'b1;
        #1;
        check_zero("reset_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_zero("reset_hold");
        end

        // Release between edges; led1 goes 1,0,1 and led3 starts 0,0,1.
        release_mid();
        run_edges(9, "post_release");

        // 100 edges of free running, counting led1 transitions.
        trans = 0;
        prev = led1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            k++;
            check_all("run100");
            if (led1 !== prev) trans++;
            prev = led1;
        end
        checks++;
        $display("check transitions100 got=%0d exp=100", trans);
        assert (trans == 100) else begin
            failures++;
            $error("FAIL transitions100 got=%0d exp=100", trans);
        end

        // Assert reset between edges while led1 is high: no edge needed.
        found = 0;
        for (int i = 0; i < 4 && found == 0; i++) begin
            if (led1 === 1'b1) found = 1;
            else run_edges(1, "seek_high");
        end
        check("seek_high_found", 1'(found), 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check_zero("mid_reset_async");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_zero("mid_reset_hold");
        end

        // Release coincident with a rising edge, then resume the sequence.
        release_on_edge("edge_release");
        run_edges(12, "after_edge_release");

        // Randomized run lengths, async reset offsets, hold lengths and release style.
        for (int r = 0; r < 25; r++) begin
            run_edges(int'($urandom_range(1, 40)), "rand_run");
            #($urandom_range(1, 8));
            rst = 1'b1;
            #1;
            check_zero("rand_reset_async");
            hold = int'($urandom_range(1, 3));
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check_zero("rand_reset_hold");
            end
            if ($urandom_range(0, 1) == 1) begin
                release_on_edge("rand_edge_release");
            end else begin
                release_mid();
            end
        end
        run_edges(10, "final_run");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
